// File: rtl/dram_cmd_sched_if.sv
// Command handshake and DRAM strobe bundle between the controller FSM (master)
// and the command-timing/refresh scheduler (slave).
interface dram_cmd_sched_if;
  logic       cmd_req;
  logic [1:0] cmd;
  logic       cmd_ack;
  logic       refresh_flag;
  logic [1:0] dram_cmd;
  logic       dram_cmd_val;
  logic       busy;
  logic       ref_overrun;

  modport master (
    output cmd_req, cmd,
    input  cmd_ack, refresh_flag, dram_cmd, dram_cmd_val, busy, ref_overrun
  );

  modport slave (
    input  cmd_req, cmd,
    output cmd_ack, refresh_flag, dram_cmd, dram_cmd_val, busy, ref_overrun
  );
endinterface

// File: rtl/dram_cmd_sched.sv
// DRAM command latency holder and refresh interval scheduler.
// Define DRAM_REF_POSTPONE_EN to allow up to 8 postponed refreshes (else 1).
module dram_cmd_sched #(
  parameter int unsigned T_ACT        = 3,
  parameter int unsigned T_COL        = 1,
  parameter int unsigned T_REF        = 8,
  parameter int unsigned T_PRE        = 2,
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic             clk,
  input  logic             rst_b,
  dram_cmd_sched_if.slave  bus
);

  localparam int unsigned LAT_W = 8;
  localparam int unsigned TMR_W = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
`ifdef DRAM_REF_POSTPONE_EN
  localparam int unsigned PEND_W   = 4;
  localparam int unsigned PEND_MAX = 8;
`else
  localparam int unsigned PEND_W   = 1;
  localparam int unsigned PEND_MAX = 1;
`endif

  localparam logic [1:0] CMD_REF = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e             state_q;
  logic [LAT_W-1:0]   lat_q;
  logic [LAT_W-1:0]   lat_sel;
  logic [1:0]         dram_cmd_q;
  logic               val_q;
  logic               ack_q;
  logic               busy_q;

  logic [TMR_W-1:0]   tmr_q;
  logic               exp_q;
  logic [PEND_W-1:0]  pend_q;
  logic [PEND_W-1:0]  pend_d;
  logic               flag_q;
  logic               ovr_q;
  logic               ovr_set;
  logic               ref_ack;
  logic               tmr_wrap;

  // Latency for the command being offered
  always_comb begin
    lat_sel = LAT_W'(T_ACT);
    unique case (bus.cmd)
      2'b00: lat_sel = LAT_W'(T_ACT);
      2'b01: lat_sel = LAT_W'(T_COL);
      2'b10: lat_sel = LAT_W'(T_REF);
      2'b11: lat_sel = LAT_W'(T_PRE);
    endcase
  end

  // Command acceptance / latency / ack / hold sequencing
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      dram_cmd_q <= 2'b00;
      val_q      <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      val_q <= 1'b0;
      ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_req) begin
            dram_cmd_q <= bus.cmd;
            lat_q      <= lat_sel;
            val_q      <= 1'b1;
            busy_q     <= 1'b1;
            if (lat_sel <= LAT_W'(1)) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          lat_q <= lat_q - LAT_W'(1);
          if (lat_q <= LAT_W'(2)) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
          end
        end
        S_ACK: state_q <= S_HOLD;
        S_HOLD: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tmr_wrap = (tmr_q == TMR_W'(REF_INTERVAL - 1));
  assign ref_ack  = (state_q == S_ACK) && (dram_cmd_q == CMD_REF);

  // Pending-refresh bookkeeping; a coincident expiry and refresh ack cancel out
  always_comb begin
    pend_d  = pend_q;
    ovr_set = 1'b0;
    if (exp_q && !ref_ack) begin
      if (pend_q == PEND_W'(PEND_MAX)) ovr_set = 1'b1;
      else                             pend_d  = pend_q + PEND_W'(1);
    end else if (!exp_q && ref_ack && (pend_q != '0)) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      tmr_q  <= '0;
      exp_q  <= 1'b0;
      pend_q <= '0;
      flag_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      tmr_q  <= tmr_wrap ? '0 : tmr_q + TMR_W'(1);
      exp_q  <= tmr_wrap;
      pend_q <= pend_d;
      flag_q <= (pend_d != '0);
      ovr_q  <= ovr_q | ovr_set;
    end
  end

  assign bus.cmd_ack      = ack_q;
  assign bus.dram_cmd     = dram_cmd_q;
  assign bus.dram_cmd_val = val_q;
  assign bus.busy         = busy_q;
  assign bus.refresh_flag = flag_q;
  assign bus.ref_overrun  = ovr_q;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Bench for dram_cmd_sched: command table plus scoreboard of strobe/ack cycles,
// and hand-written refresh, overrun and mid-command reset sequences.
module tb_dram_cmd_sched;

  localparam int unsigned REF_IV = 20;

  logic clk   = 1'b0;
  logic rst_b = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic ack_flag = 1'b0;

  dram_cmd_sched_if bus ();

  dram_cmd_sched #(
    .T_ACT(3), .T_COL(1), .T_REF(8), .T_PRE(2), .REF_INTERVAL(REF_IV)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after the last reset edge
  always @(posedge clk) begin
    if (rst_b) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [1:0] cmd;
  } exp_t;

  typedef struct {
    logic [1:0] cmd;
    int         lat;
    bit         scramble;
  } vec_t;

  exp_t val_sb[$];
  exp_t ack_sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every strobe and ack must match the next expected entry
  always @(negedge clk) begin
    exp_t e;
    if (bus.dram_cmd_val === 1'b1) begin
      check("val_expected", 32'(val_sb.size() != 0), 32'd1);
      if (val_sb.size() != 0) begin
        e = val_sb.pop_front();
        check("val_cycle", 32'(cyc), 32'(e.cyc));
        check("val_cmd", 32'(bus.dram_cmd), 32'(e.cmd));
      end
    end
    if (bus.cmd_ack === 1'b1) begin
      ack_flag = bus.refresh_flag;
      check("ack_expected", 32'(ack_sb.size() != 0), 32'd1);
      if (ack_sb.size() != 0) begin
        e = ack_sb.pop_front();
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("ack_cmd_stable", 32'(bus.dram_cmd), 32'(e.cmd));
        check("ack_busy", 32'(bus.busy), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      tick();
      guard++;
    end
    check("schedule", 32'(cyc), 32'(n));
  endtask

  task automatic sample_at(input int n);
    goto_cyc(n);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_b       = 1'b1;
    bus.cmd_req = 1'b0;
    bus.cmd     = 2'b00;
    tick();
    tick();
    rst_b = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ack"}, 32'(bus.cmd_ack), 32'd0);
    check({tag, "_refresh_flag"}, 32'(bus.refresh_flag), 32'd0);
    check({tag, "_dram_cmd"}, 32'(bus.dram_cmd), 32'd0);
    check({tag, "_dram_cmd_val"}, 32'(bus.dram_cmd_val), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_ref_overrun"}, 32'(bus.ref_overrun), 32'd0);
  endtask

  // Offer a command in the current (idle) cycle; returns in the HOLD cycle
  task automatic issue(input logic [1:0] c, input int lat, input bit scramble, input bit hold_req);
    bit got = 1'b0;
    val_sb.push_back('{cyc: cyc + 1, cmd: c});
    ack_sb.push_back('{cyc: cyc + lat, cmd: c});
    bus.cmd_req = 1'b1;
    bus.cmd     = c;
    if (scramble) begin
      tick();
      bus.cmd = ~c;
    end
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      got = (bus.cmd_ack === 1'b1);
    end
    check("ack_timeout", 32'(got), 32'd1);
    tick();
    if (!hold_req) bus.cmd_req = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int   n_exp;
    int   ovr_cyc;

    vecs[0] = '{cmd: 2'b11, lat: 2, scramble: 1'b0};
    vecs[1] = '{cmd: 2'b00, lat: 3, scramble: 1'b0};
    vecs[2] = '{cmd: 2'b01, lat: 1, scramble: 1'b0};
    vecs[3] = '{cmd: 2'b10, lat: 8, scramble: 1'b1};
    vecs[4] = '{cmd: 2'b01, lat: 1, scramble: 1'b1};
    vecs[5] = '{cmd: 2'b11, lat: 2, scramble: 1'b1};
`ifdef DRAM_REF_POSTPONE_EN
    n_exp = 9;
`else
    n_exp = 2;
`endif
    ovr_cyc = n_exp * int'(REF_IV) + 1;

    bus.cmd_req = 1'b0;
    bus.cmd     = 2'b00;

    // Reset values and the held-request re-accept window
    do_reset();
    @(negedge clk);
    check_reset_outputs("rst");
    goto_cyc(5);
    issue(2'b00, 3, 1'b0, 1'b1);
    @(negedge clk);
    check("hold_busy", 32'(bus.busy), 32'd1);
    goto_cyc(10);
    issue(2'b00, 3, 1'b0, 1'b0);
    sample_at(20);
    check("flag_before_expiry", 32'(bus.refresh_flag), 32'd0);
    sample_at(21);
    check("flag_after_expiry", 32'(bus.refresh_flag), 32'd1);

    // Back-to-back commands, some with cmd changing while busy
    goto_cyc(22);
    foreach (vecs[i]) begin
      issue(vecs[i].cmd, vecs[i].lat, vecs[i].scramble, 1'b0);
      tick();
    end

    // Refresh ack coincident with expiry, then an ordinary refresh clearing the flag
    do_reset();
    sample_at(21);
    check("p2_flag_rise", 32'(bus.refresh_flag), 32'd1);
    goto_cyc(32);
    issue(2'b10, 8, 1'b0, 1'b0);
    @(negedge clk);
    check("coincident_flag_kept", 32'(bus.refresh_flag), 32'd1);
    goto_cyc(42);
    issue(2'b10, 8, 1'b0, 1'b0);
    check("flag_high_at_ack", 32'(ack_flag), 32'd1);
    @(negedge clk);
    check("flag_fall_after_ack", 32'(bus.refresh_flag), 32'd0);

    // Unserviced refreshes overrun; the error is sticky until reset
    do_reset();
    sample_at(ovr_cyc - 1);
    check("overrun_not_yet", 32'(bus.ref_overrun), 32'd0);
    sample_at(ovr_cyc);
    check("overrun_set", 32'(bus.ref_overrun), 32'd1);
    check("overrun_flag", 32'(bus.refresh_flag), 32'd1);
    goto_cyc(ovr_cyc + 1);
    issue(2'b10, 8, 1'b0, 1'b0);
    @(negedge clk);
    check("overrun_sticky", 32'(bus.ref_overrun), 32'd1);

    // Reset in the middle of a refresh aborts it without an ack
    do_reset();
    @(negedge clk);
    check_reset_outputs("rst2");
    goto_cyc(3);
    val_sb.push_back('{cyc: 4, cmd: 2'b10});
    bus.cmd_req = 1'b1;
    bus.cmd     = 2'b10;
    tick();
    bus.cmd_req = 1'b0;
    sample_at(6);
    check("mid_busy", 32'(bus.busy), 32'd1);
    tick();
    rst_b = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs("abort");
    tick();
    rst_b = 1'b0;
    goto_cyc(12);
    issue(2'b01, 1, 1'b0, 1'b0);
    tick();
    issue(2'b00, 3, 1'b0, 1'b0);
    tick();
    tick();

    check("scoreboard_drained", 32'(val_sb.size() + ack_sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dram_cmd_sched.md
# dram_cmd_sched

Command-timing and refresh scheduler directly downstream of the DRAM controller FSM. It accepts the FSM's `cmd_req`/`cmd` handshake and holds each command for its DRAM timing latency. It then returns a one-cycle `cmd_ack`. It also owns the refresh interval timer that produces `refresh_flag` back to the FSM, and it issues registered command strobes toward the DRAM device model.

## Interface
Parameters:
- `T_ACT`, 3: cycles from accepting ACT/RW (cmd 00) to `cmd_ack`; legal range 1..255.
- `T_COL`, 1: cycles for cmd 01 (column access); legal range 1..255.
- `T_REF`, 8: cycles for REFRESH (cmd 10), i.e. tRFC; legal range 1..255.
- `T_PRE`, 2: cycles for PRECHARGE (cmd 11), i.e. tRP; legal range 1..255.
- `REF_INTERVAL`, 780: cycles between refresh requests; must be ≥ 2.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_b` in 1: reset, synchronous and active-high (1 = reset).
- `cmd_req` in 1: level request from the FSM.
- `cmd` in 2: command code. 00 ACT/RW, 01 COL, 10 REFRESH, 11 PRECHARGE.
- `cmd_ack` out 1: one-cycle completion pulse.
- `refresh_flag` out 1: at least one refresh is pending.
- `dram_cmd` out 2: command latched at acceptance.
- `dram_cmd_val` out 1: one-cycle pulse in the cycle after acceptance.
- `busy` out 1: high in BUSY, ACK and HOLD.
- `ref_overrun` out 1: sticky error; set when a refresh interval expires and the pending count is already at its limit.

## Operation
- State machine with four states: IDLE, BUSY, ACK, HOLD.
- IDLE:
  - If `cmd_req`=1, latch `cmd` into `dram_cmd` and load the latency counter with the matching T_x.
  - Go to ACK if T_x=1, otherwise go to BUSY.
- BUSY: decrement the counter each cycle. When the counter reaches 1, go to ACK.
- ACK: `cmd_ack`=1 for exactly this cycle; go to HOLD.
- HOLD: ignore `cmd_req` for one cycle, because the FSM drops its registered request one cycle after the ack. Then go to IDLE.
- `cmd` is sampled only at acceptance. Changes to `cmd` while busy are ignored.
- `cmd_req` dropping while in BUSY does not abort the command. The ack is still produced.
- Refresh timer:
  - Free-running counter from 0 to REF_INTERVAL-1; width $clog2(REF_INTERVAL).
  - It wraps to 0 and raises an expiry pulse on the REF_INTERVAL-1 → 0 transition.
- Pending-refresh counter `ref_pend`:
  - +1 on expiry.
  - −1 when a REFRESH command is acked (ACK state with latched cmd=10).
  - Expiry and refresh ack in the same cycle: count unchanged.
  - `refresh_flag` = (`ref_pend` != 0).
  - Expiry with `ref_pend` at its limit: the count saturates and `ref_overrun` sets. It clears only on reset.
  - Acking a REFRESH with `ref_pend`=0 is legal. The count stays 0.
- The timer keeps running in every state, including during a refresh.

## Timing
- Reset values: `cmd_ack`=0, `refresh_flag`=0, `dram_cmd`=00, `dram_cmd_val`=0, `busy`=0, `ref_overrun`=0. State IDLE, timer 0, `ref_pend` 0.
- Acceptance in cycle A gives:
  - `dram_cmd_val`=1 in cycle A+1;
  - `cmd_ack`=1 in cycle A+T_x;
  - HOLD in cycle A+T_x+1;
  - earliest next acceptance in cycle A+T_x+2.
- With T_x=1, `dram_cmd_val` and `cmd_ack` are both high in cycle A+1.
- The first expiry occurs REF_INTERVAL cycles after reset is released. `refresh_flag` rises in the following cycle (registered).
- Reset asserted mid-command: return to IDLE on the next edge with no `cmd_ack`. The timer and `ref_pend` clear.

## Configuration
- `DRAM_REF_POSTPONE_EN` defined:
  - `ref_pend` is 4 bits with a limit of 8 (JEDEC postpone depth).
  - The overrun condition is expiry with `ref_pend`=8.
- Undefined:
  - `ref_pend` is a single bit with a limit of 1.
  - A second expiry before the refresh ack sets `ref_overrun`.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then `cmd_req`=1 with cmd=00 at cycle 5 → `dram_cmd_val` at cycle 6 and `cmd_ack` pulse at cycle 8 (T_ACT=3). A held `cmd_req` is not re-accepted until cycle 10.
- Back-to-back 11 then 00 with the FSM dropping `cmd_req` after the ack → acks exactly T_PRE and T_ACT cycles after each acceptance, and exactly one `dram_cmd_val` per command.
- REF_INTERVAL=20, no commands → `refresh_flag` rises at cycle 21 after reset release. Issue cmd=10 → ack after 8 cycles, and `refresh_flag` falls the cycle after the ack.
- Refresh ack in the same cycle as an expiry → `ref_pend` unchanged and `refresh_flag` stays high.
- No refreshes serviced:
  - with the macro, `ref_overrun` sets on the 9th expiry;
  - without the macro, it sets on the 2nd expiry.
  - In both builds it stays set until `rst_b`.
- `rst_b` asserted in BUSY mid-T_REF → no `cmd_ack`, all outputs at reset values the next cycle, and a new command is accepted normally afterwards.
